// File: rtl/jx2_mem_arb_n_pkg.sv
// Shared memory-port definitions for the N-channel miss arbiter: opm/status codes,
// arbiter state encoding and the round-robin pointer helper.
package jx2_mem_arb_n_pkg;

    localparam logic [4:0] UMEM_OPM_READY = 5'h00;

    localparam logic [1:0] UMEM_OK_READY = 2'b00;
    localparam logic [1:0] UMEM_OK_OK    = 2'b01;
    localparam logic [1:0] UMEM_OK_HOLD  = 2'b10;
    localparam logic [1:0] UMEM_OK_FAULT = 2'b11;

    localparam int unsigned MARB_MAX_CH = 8;

    typedef enum logic [1:0] {
        JX2_MARB_IDLE = 2'd0,
        JX2_MARB_BUSY = 2'd1,
        JX2_MARB_DONE = 2'd2
    } jx2MarbState;

    function automatic logic [2:0] rrNext(input logic [2:0] id, input int unsigned nch);
        if ({29'd0, id} + 32'd1 >= nch) return 3'd0;
        return id + 3'd1;
    endfunction

endpackage

// File: rtl/jx2_mem_arb_n_if.sv
// Cache-miss channel bundle and memory-tile port seen by the arbiter.
// slave = arbiter side, master = cache/memory side driving requests and responses.
interface jx2_mem_arb_n_if #(
    parameter int unsigned NCH    = 2,
    parameter int unsigned ADDR_W = 48,
    parameter int unsigned DATA_W = 128
);
    logic [NCH*ADDR_W-1:0] chReqAddr;
    logic [NCH*DATA_W-1:0] chReqData;
    logic [NCH*5-1:0]      chReqOpm;
    logic [DATA_W-1:0]     chRspData;
    logic [NCH*2-1:0]      chRspOK;
    logic [ADDR_W-1:0]     memAddr;
    logic [DATA_W-1:0]     memDataO;
    logic [4:0]            memOpm;
    logic [DATA_W-1:0]     memDataI;
    logic [1:0]            memOK;
    logic [2:0]            grantId;
    logic                  arbBusy;

    modport slave (
        input  chReqAddr, chReqData, chReqOpm, memDataI, memOK,
        output chRspData, chRspOK, memAddr, memDataO, memOpm, grantId, arbBusy
    );

    modport master (
        output chReqAddr, chReqData, chReqOpm, memDataI, memOK,
        input  chRspData, chRspOK, memAddr, memDataO, memOpm, grantId, arbBusy
    );
endinterface

// File: rtl/jx2_arb_pick.sv
// Combinational winner picker: fixed priority (lowest index) or round robin starting
// at rrPtr with wrap at NCH-1. Shared with the interrupt controller.
module jx2_arb_pick #(
    parameter int unsigned NCH = 2
) (
    input  logic [NCH-1:0] reqVec,
    input  logic [2:0]     rrPtr,
    input  logic           rrMode,
    output logic [2:0]     winIdx,
    output logic           winValid
);

    logic [7:0] reqPad;

    assign reqPad = 8'(reqVec);

    always_comb begin
        int unsigned j;
        logic [2:0]  idx;
        j        = 0;
        idx      = 3'd0;
        winIdx   = 3'd0;
        winValid = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            j = k;
            if (rrMode) j = j + {29'd0, rrPtr};
            if (j >= NCH) j = j - NCH;
            idx = 3'(j);
            if (!winValid && reqPad[idx]) begin
                winValid = 1'b1;
                winIdx   = idx;
            end
        end
    end

endmodule

// File: rtl/jx2_mem_arb_n.sv
// N-channel arbiter between L1 miss ports and the single memory tile port, with
// registered request latching, 4-phase completion handshake and BUSY timeout.
module jx2_mem_arb_n
    import jx2_mem_arb_n_pkg::*;
#(
    parameter int unsigned NCH      = 2,
    parameter int unsigned ADDR_W   = 48,
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned TMO_CYC  = 1024
) (
    input logic            clock,
    input logic            reset,
    jx2_mem_arb_n_if.slave bus
);

    localparam logic [31:0] TMO_LAST = 32'(TMO_CYC) - 32'd1;

    logic [ADDR_W-1:0] addrArr [MARB_MAX_CH];
    logic [DATA_W-1:0] dataArr [MARB_MAX_CH];
    logic [4:0]        opmArr  [MARB_MAX_CH];
    logic [NCH-1:0]    reqVec;

    jx2MarbState       state;
    logic [2:0]        rrPtr;
    logic [2:0]        grantQ;
    logic [31:0]       tmoCnt;
    logic [1:0]        stStat;
    logic [ADDR_W-1:0] memAddrQ;
    logic [DATA_W-1:0] memDataQ;
    logic [4:0]        memOpmQ;
    logic [DATA_W-1:0] rspDataQ;
    logic [2:0]        winIdx;
    logic              winValid;

    // Pad to 8 entries so a 3-bit grant index always lands on a defined slot.
    for (genvar g = 0; g < MARB_MAX_CH; g++) begin : gCh
        if (g < NCH) begin : gLive
            logic [1:0] rspOk;

            assign addrArr[g] = bus.chReqAddr[g*ADDR_W +: ADDR_W];
            assign dataArr[g] = bus.chReqData[g*DATA_W +: DATA_W];
            assign opmArr[g]  = bus.chReqOpm[g*5 +: 5];
            assign reqVec[g]  = (opmArr[g] != UMEM_OPM_READY);

            always_comb begin
                if (!reset) begin
                    rspOk = UMEM_OK_READY;
                end else if (grantQ == 3'(g) && state == JX2_MARB_BUSY) begin
                    rspOk = UMEM_OK_HOLD;
                end else if (grantQ == 3'(g) && state == JX2_MARB_DONE) begin
                    rspOk = stStat;
                end else begin
                    rspOk = reqVec[g] ? UMEM_OK_HOLD : UMEM_OK_READY;
                end
            end

            assign bus.chRspOK[g*2 +: 2] = rspOk;
        end else begin : gPad
            assign addrArr[g] = '0;
            assign dataArr[g] = '0;
            assign opmArr[g]  = UMEM_OPM_READY;
        end
    end

    jx2_arb_pick #(
        .NCH (NCH)
    ) uPick (
        .reqVec   (reqVec),
        .rrPtr    (rrPtr),
        .rrMode   (ARB_MODE == 1),
        .winIdx   (winIdx),
        .winValid (winValid)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= JX2_MARB_IDLE;
            rrPtr    <= 3'd0;
            grantQ   <= 3'd0;
            tmoCnt   <= 32'd0;
            stStat   <= UMEM_OK_READY;
            memAddrQ <= '0;
            memDataQ <= '0;
            memOpmQ  <= UMEM_OPM_READY;
            rspDataQ <= '0;
        end else begin
            case (state)
                JX2_MARB_IDLE: begin
                    if (winValid) begin
                        memAddrQ <= addrArr[winIdx];
                        memDataQ <= dataArr[winIdx];
                        memOpmQ  <= opmArr[winIdx];
                        grantQ   <= winIdx;
                        tmoCnt   <= 32'd0;
                        state    <= JX2_MARB_BUSY;
                    end
                end
                JX2_MARB_BUSY: begin
                    tmoCnt <= tmoCnt + 32'd1;
                    if (bus.memOK == UMEM_OK_OK || bus.memOK == UMEM_OK_FAULT) begin
                        rspDataQ <= bus.memDataI;
                        stStat   <= bus.memOK;
                        memOpmQ  <= UMEM_OPM_READY;
                        state    <= JX2_MARB_DONE;
                    end else if (TMO_CYC != 0 && tmoCnt == TMO_LAST) begin
                        // Response data is left untouched on timeout.
                        stStat  <= UMEM_OK_FAULT;
                        memOpmQ <= UMEM_OPM_READY;
                        state   <= JX2_MARB_DONE;
                    end
                end
                JX2_MARB_DONE: begin
                    if (opmArr[grantQ] == UMEM_OPM_READY && bus.memOK == UMEM_OK_READY) begin
                        state <= JX2_MARB_IDLE;
                        if (ARB_MODE == 1) rrPtr <= rrNext(grantQ, NCH);
                    end
                end
                default: state <= JX2_MARB_IDLE;
            endcase
        end
    end

    assign bus.memAddr   = memAddrQ;
    assign bus.memDataO  = memDataQ;
    assign bus.memOpm    = memOpmQ;
    assign bus.chRspData = rspDataQ;
    assign bus.grantId   = grantQ;
    assign bus.arbBusy   = (state != JX2_MARB_IDLE);

endmodule

// File: tb/tb_jx2_mem_arb_n.sv
// Bench for jx2_mem_arb_n: a 2-channel fixed-priority instance and a 4-channel
// round-robin instance, both with a 16-cycle timeout, against a queue-free reference model.
module tb_jx2_mem_arb_n;

    localparam logic [1:0] K_READY = 2'b00;
    localparam logic [1:0] K_OK    = 2'b01;
    localparam logic [1:0] K_HOLD  = 2'b10;
    localparam logic [1:0] K_FAULT = 2'b11;

    logic clock = 1'b0;
    logic reset;
    int   nTests = 0;
    int   nFail  = 0;

    always #5 clock = ~clock;

    jx2_mem_arb_n_if #(.NCH(2), .ADDR_W(48), .DATA_W(128)) busA ();
    jx2_mem_arb_n_if #(.NCH(4), .ADDR_W(48), .DATA_W(128)) busB ();

    jx2_mem_arb_n #(
        .NCH(2), .ADDR_W(48), .DATA_W(128), .ARB_MODE(0), .TMO_CYC(16)
    ) dutA (
        .clock (clock),
        .reset (reset),
        .bus   (busA)
    );

    jx2_mem_arb_n #(
        .NCH(4), .ADDR_W(48), .DATA_W(128), .ARB_MODE(1), .TMO_CYC(16)
    ) dutB (
        .clock (clock),
        .reset (reset),
        .bus   (busB)
    );

    // Reference state for the round-robin instance.
    logic [47:0]  mAddr [4];
    logic [127:0] mData [4];
    logic [4:0]   mOpm  [4];
    int           waitCnt [4];
    int           rrModel;
    logic [127:0] expRsp;

    logic [4:0]   aOpm  [2];
    logic [47:0]  aAddr [2];
    logic [127:0] aData [2];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic driveB();
        for (int i = 0; i < 4; i++) begin
            busB.chReqAddr[i*48 +: 48]   = mAddr[i];
            busB.chReqData[i*128 +: 128] = mData[i];
            busB.chReqOpm[i*5 +: 5]      = mOpm[i];
        end
    endtask

    task automatic driveA();
        for (int i = 0; i < 2; i++) begin
            busA.chReqAddr[i*48 +: 48]   = aAddr[i];
            busA.chReqData[i*128 +: 128] = aData[i];
            busA.chReqOpm[i*5 +: 5]      = aOpm[i];
        end
    endtask

    task automatic randReq(input int i);
        mAddr[i] = 48'({$urandom(), $urandom()});
        mData[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        mOpm[i]  = 5'($urandom_range(1, 31));
    endtask

    function automatic logic [1:0] okB(input int i);
        return busB.chRspOK[i*2 +: 2];
    endfunction

    function automatic logic [1:0] okA(input int i);
        return busA.chRspOK[i*2 +: 2];
    endfunction

    // One round-robin transaction. fin: 0 = OK, 1 = FAULT, 2 = no reply (timeout).
    task automatic run_txn_b(input int lat, input int fin, input int holdN, input bit dropEarly);
        int           w;
        int           gotW;
        int           nb;
        logic [47:0]  eA;
        logic [127:0] eD;
        logic [127:0] rnd;
        logic [4:0]   eO;
        logic [1:0]   eStat;
        logic [3:0]   reqMask;
        w = -1;
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (rrModel + k) % 4;
            reqMask[k] = (mOpm[k] != 5'd0);
            if (w < 0 && mOpm[j] != 5'd0) w = j;
        end
        if (w < 0) begin
            randReq(rrModel);
            driveB();
            w = rrModel;
            reqMask[w] = 1'b1;
        end
        eA = mAddr[w];
        eD = mData[w];
        eO = mOpm[w];
        eStat = K_FAULT;

        tick();
        gotW = int'(busB.grantId);
        nTests++;
        if (busB.grantId !== 3'(w) || busB.memAddr !== eA || busB.memDataO !== eD ||
            busB.memOpm !== eO || busB.arbBusy !== 1'b1) begin
            nFail++;
            $display("FAIL grantB: got ch=%0d addr=%h opm=%h busy=%b, want ch=%0d addr=%h opm=%h busy=1",
                     busB.grantId, busB.memAddr, busB.memOpm, busB.arbBusy, w, eA, eO);
        end

        // Scramble the granted channel's inputs; the latched request must not move.
        mAddr[w] = mAddr[w] ^ 48'h3000;
        mData[w] = ~mData[w];
        mOpm[w]  = dropEarly ? 5'd0 : ((eO == 5'h1f) ? 5'h01 : eO + 5'd1);
        driveB();
        busB.memOK = K_HOLD;
        #1;

        nb = (fin == 2) ? 15 : lat;
        for (int c = 0; c <= nb; c++) begin
            nTests++;
            if (okB(w) !== K_HOLD || busB.memAddr !== eA || busB.memDataO !== eD ||
                busB.memOpm !== eO || busB.arbBusy !== 1'b1) begin
                nFail++;
                $display("FAIL busyB cyc%0d: got ok=%0d addr=%h opm=%h busy=%b, want ok=2 addr=%h opm=%h busy=1",
                         c, okB(w), busB.memAddr, busB.memOpm, busB.arbBusy, eA, eO);
            end
            for (int i = 0; i < 4; i++) begin
                if (i != w) begin
                    nTests++;
                    if (okB(i) !== ((mOpm[i] != 5'd0) ? K_HOLD : K_READY)) begin
                        nFail++;
                        $display("FAIL otherOkB ch%0d: got %0d want %0d", i, okB(i),
                                 (mOpm[i] != 5'd0) ? K_HOLD : K_READY);
                    end
                end
            end
            if (c < nb) tick();
        end

        if (fin != 2) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            busB.memDataI = rnd;
            busB.memOK = (fin == 0) ? K_OK : K_FAULT;
            eStat = (fin == 0) ? K_OK : K_FAULT;
            expRsp = rnd;
        end
        tick();
        busB.memOK = K_READY;
        busB.memDataI = {$urandom(), $urandom(), $urandom(), $urandom()};
        #1;
        nTests++;
        if (okB(w) !== eStat || busB.chRspData !== expRsp || busB.memOpm !== 5'd0 ||
            busB.arbBusy !== 1'b1 || busB.grantId !== 3'(w)) begin
            nFail++;
            $display("FAIL doneB: got ok=%0d data=%h opm=%h busy=%b, want ok=%0d data=%h opm=0 busy=1",
                     okB(w), busB.chRspData, busB.memOpm, busB.arbBusy, eStat, expRsp);
        end

        if (!dropEarly) begin
            for (int h = 0; h < holdN; h++) begin
                tick();
                nTests++;
                if (okB(w) !== eStat || busB.arbBusy !== 1'b1 || busB.grantId !== 3'(w)) begin
                    nFail++;
                    $display("FAIL holdB cyc%0d: got ok=%0d busy=%b ch=%0d, want ok=%0d busy=1 ch=%0d",
                             h, okB(w), busB.arbBusy, busB.grantId, eStat, w);
                end
            end
            mOpm[w] = 5'd0;
            driveB();
        end

        tick();
        nTests++;
        if (busB.arbBusy !== 1'b0 || okB(w) !== K_READY) begin
            nFail++;
            $display("FAIL idleB: got busy=%b ok=%0d, want busy=0 ok=0", busB.arbBusy, okB(w));
        end

        rrModel = (w + 1) % 4;
        for (int i = 0; i < 4; i++) begin
            if (i == gotW) waitCnt[i] = 0;
            else if (reqMask[i]) waitCnt[i]++;
            else waitCnt[i] = 0;
            nTests++;
            if (waitCnt[i] > 3) begin
                nFail++;
                $display("FAIL starveB ch%0d: waited %0d transactions, want <= 3", i, waitCnt[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) randReq(i);
        driveB();
        for (int i = 0; i < 2; i++) begin
            aAddr[i] = 48'd0;
            aData[i] = 128'd0;
            aOpm[i]  = 5'h5;
        end
        driveA();
        busA.memOK = K_READY;
        busB.memOK = K_READY;
        busA.memDataI = '0;
        busB.memDataI = '0;
        #2;
        nTests++;
        if (busA.memOpm !== 5'd0 || busA.memAddr !== 48'd0 || busA.memDataO !== 128'd0 ||
            busA.chRspData !== 128'd0 || busA.grantId !== 3'd0 || busA.arbBusy !== 1'b0) begin
            nFail++;
            $display("FAIL resetA: got opm=%h addr=%h grant=%0d busy=%b, want all zero",
                     busA.memOpm, busA.memAddr, busA.grantId, busA.arbBusy);
        end
        nTests++;
        if (busB.memOpm !== 5'd0 || busB.memAddr !== 48'd0 || busB.memDataO !== 128'd0 ||
            busB.chRspData !== 128'd0 || busB.grantId !== 3'd0 || busB.arbBusy !== 1'b0) begin
            nFail++;
            $display("FAIL resetB: got opm=%h addr=%h grant=%0d busy=%b, want all zero",
                     busB.memOpm, busB.memAddr, busB.grantId, busB.arbBusy);
        end
        nTests++;
        if (busA.chRspOK !== 4'd0 || busB.chRspOK !== 8'd0) begin
            nFail++;
            $display("FAIL resetOk: got A=%b B=%b, want all READY", busA.chRspOK, busB.chRspOK);
        end
        for (int i = 0; i < 4; i++) begin
            mOpm[i] = 5'd0;
            waitCnt[i] = 0;
        end
        aOpm[0] = 5'd0;
        aOpm[1] = 5'd0;
        driveA();
        driveB();
        rrModel = 0;
        expRsp = '0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        tick();
        nTests++;
        if (busA.arbBusy !== 1'b0 || busB.arbBusy !== 1'b0) begin
            nFail++;
            $display("FAIL quietIdle: got busyA=%b busyB=%b, want 0 0", busA.arbBusy, busB.arbBusy);
        end
    endtask

    task automatic test_fixed_priority();
        int           w;
        int           o;
        logic [127:0] rsp;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 2; i++) begin
                aAddr[i] = 48'({$urandom(), $urandom()});
                aData[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
                aOpm[i]  = (r < 2 || $urandom_range(0, 1) == 1) ? 5'($urandom_range(1, 31)) : 5'd0;
            end
            if (aOpm[0] == 5'd0 && aOpm[1] == 5'd0) aOpm[1] = 5'h3;
            driveA();
            for (int t = 0; t < 2; t++) begin
                if (aOpm[0] == 5'd0 && aOpm[1] == 5'd0) break;
                w = (aOpm[0] != 5'd0) ? 0 : 1;
                o = 1 - w;
                tick();
                busA.memOK = K_HOLD;
                nTests++;
                if (busA.grantId !== 3'(w) || busA.memAddr !== aAddr[w] ||
                    busA.memDataO !== aData[w] || busA.memOpm !== aOpm[w]) begin
                    nFail++;
                    $display("FAIL grantA r%0d: got ch=%0d addr=%h opm=%h, want ch=%0d addr=%h opm=%h",
                             r, busA.grantId, busA.memAddr, busA.memOpm, w, aAddr[w], aOpm[w]);
                end
                for (int c = 0; c < 3; c++) begin
                    nTests++;
                    if (okA(w) !== K_HOLD || okA(o) !== ((aOpm[o] != 5'd0) ? K_HOLD : K_READY)) begin
                        nFail++;
                        $display("FAIL holdA r%0d: got ok%0d=%0d ok%0d=%0d, want HOLD for requesters",
                                 r, w, okA(w), o, okA(o));
                    end
                    tick();
                end
                rsp = (r == 0 && t == 0) ? 128'h00112233_44556677_8899AABB_CCDDEEFF
                                         : {$urandom(), $urandom(), $urandom(), $urandom()};
                busA.memDataI = rsp;
                busA.memOK = K_OK;
                tick();
                busA.memOK = K_READY;
                nTests++;
                if (okA(w) !== K_OK || busA.chRspData !== rsp || busA.memOpm !== 5'd0 ||
                    okA(o) !== ((aOpm[o] != 5'd0) ? K_HOLD : K_READY)) begin
                    nFail++;
                    $display("FAIL doneA r%0d: got ok=%0d data=%h other=%0d, want ok=1 data=%h",
                             r, okA(w), busA.chRspData, okA(o), rsp);
                end
                aOpm[w] = 5'd0;
                driveA();
                tick();
                nTests++;
                if (busA.arbBusy !== 1'b0) begin
                    nFail++;
                    $display("FAIL idleA r%0d: got busy=%b want 0", r, busA.arbBusy);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 4; i++) randReq(i);
        driveB();
        for (int t = 0; t < 8; t++) begin
            run_txn_b($urandom_range(0, 4), 0, 0, 1'b0);
            for (int i = 0; i < 4; i++) if (mOpm[i] == 5'd0) randReq(i);
            driveB();
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 16; t++) begin
            run_txn_b($urandom_range(0, 10), $urandom_range(0, 1), $urandom_range(0, 2),
                      $urandom_range(0, 3) == 0);
            for (int i = 0; i < 4; i++) if (mOpm[i] == 5'd0 && $urandom_range(0, 1) == 1) randReq(i);
            if (mOpm[0] == 0 && mOpm[1] == 0 && mOpm[2] == 0 && mOpm[3] == 0)
                randReq($urandom_range(0, 3));
            driveB();
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 4; i++) mOpm[i] = 5'd0;
        randReq(1);
        driveB();
        run_txn_b(0, 2, 0, 1'b0);
        randReq(3);
        driveB();
        run_txn_b(3, 0, 0, 1'b0);
    endtask

    task automatic test_addr_hold();
        for (int i = 0; i < 4; i++) mOpm[i] = 5'd0;
        randReq(2);
        mAddr[2] = 48'h1000;
        driveB();
        run_txn_b(4, 0, 0, 1'b0);
    endtask

    task automatic test_done_hold();
        randReq($urandom_range(0, 3));
        driveB();
        run_txn_b(2, 0, 5, 1'b0);
    endtask

    task automatic test_reset_busy();
        for (int i = 0; i < 4; i++) if (mOpm[i] == 5'd0) randReq(i);
        driveB();
        run_txn_b(1, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) if (mOpm[i] == 5'd0) randReq(i);
        driveB();
        if (rrModel == 0) begin
            run_txn_b(1, 0, 0, 1'b0);
            for (int i = 0; i < 4; i++) if (mOpm[i] == 5'd0) randReq(i);
            driveB();
        end
        tick();
        busB.memOK = K_HOLD;
        tick();
        #3 reset = 1'b0;
        busB.memOK = K_READY;
        #1;
        nTests++;
        if (busB.memOpm !== 5'd0 || busB.chRspOK !== 8'd0 || busB.arbBusy !== 1'b0 ||
            busB.grantId !== 3'd0) begin
            nFail++;
            $display("FAIL resetBusy: got opm=%h ok=%b busy=%b grant=%0d, want 0 0 0 0",
                     busB.memOpm, busB.chRspOK, busB.arbBusy, busB.grantId);
        end
        #2 reset = 1'b1;
        rrModel = 0;
        expRsp = '0;
        for (int i = 0; i < 4; i++) waitCnt[i] = 0;
        run_txn_b(2, 0, 0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_random();
        test_timeout();
        test_addr_hold();
        test_done_hold();
        test_reset_busy();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/jx2_mem_arb_n.md
Name: jx2_mem_arb_n

Overview:
- N-channel arbiter between L1 cache miss ports (I-cache, D-cache, future TLB/walker/DMA) and the single conjoined memory tile port.
- Generalises the fixed IC-over-DC combinational mux with several additions:
  - parametric channel count
  - selectable fixed-priority or round-robin policy
  - registered request latching
  - 4-phase completion handshake
  - per-transaction timeout returning FAULT
- Sits inside the execute unit between the cache tiles and the memory tile.

Parameters:
NCH, 2, number of requesting channels (2..8); channel 0 = I-cache.
ADDR_W, 48, request address width.
DATA_W, 128, line data width.
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round robin.
TMO_CYC, 1024, cycles in BUSY before a FAULT is forced; 0 disables the timeout.

Ports:
clock  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
chReqAddr  in  NCH*ADDR_W  per-channel request address, channel i at slice [i*ADDR_W +: ADDR_W].
chReqData  in  NCH*DATA_W  per-channel store data.
chReqOpm  in  NCH*5  per-channel operation mode; UMEM_OPM_READY (0) means no request.
chRspData  out  DATA_W  load data, broadcast to all channels; valid only with OK at the granted channel.
chRspOK  out  NCH*2  per-channel status (UMEM_OK_READY/OK/HOLD/FAULT).
memAddr  out  ADDR_W  address to the memory tile.
memDataO  out  DATA_W  store data to the memory tile.
memOpm  out  5  operation mode to the memory tile.
memDataI  in  DATA_W  load data from the memory tile.
memOK  in  2  memory tile status.
grantId  out  3  index of the current or last granted channel.
arbBusy  out  1  high in BUSY or DONE.

Behaviour:
- States: IDLE, BUSY, DONE. All state is registered; the only combinational path is chReqOpm to chRspOK (HOLD/READY).
- Reset (reset low, async):
  - state = IDLE; rrPtr = 0; grantId = 0; tmoCnt = 0.
  - memOpm = READY; memAddr = 0; memDataO = 0; chRspData = 0.
  - every chRspOK = READY.
- IDLE:
  - Pick a winner among channels with chReqOpm != 0.
  - Mode 0: lowest index wins.
  - Mode 1: first requester at or after rrPtr, scanning upward with wrap at NCH-1 to 0.
  - On the next edge, latch the winner's addr/data/opm into memAddr/memDataO/memOpm, set grantId, clear tmoCnt, go to BUSY.
  - First memory-visible cycle is 1 clock after the request is seen.
- BUSY:
  - memAddr/memDataO/memOpm hold their latched values; later changes on chReqAddr/chReqData/chReqOpm are ignored.
  - tmoCnt increments every cycle.
  - memOK == OK: capture memDataI into chRspData, memOpm = READY, go to DONE.
  - memOK == FAULT: same as OK, but the stored status is FAULT.
  - TMO_CYC != 0 and tmoCnt == TMO_CYC-1 with no OK/FAULT: memOpm = READY, stored status = FAULT, chRspData unchanged, go to DONE.
- DONE:
  - Granted channel sees the stored OK/FAULT, held steady.
  - Exit to IDLE when the granted chReqOpm == READY and memOK == READY are seen in the same cycle.
  - On exit in mode 1: rrPtr = grantId+1, wrapping to 0 at NCH.
  - A channel re-asserting on the IDLE cycle is re-arbitrated normally.
- chRspOK per channel (combinational from state and chReqOpm):
  - Granted channel in BUSY: HOLD.
  - Granted channel in DONE: stored status.
  - Any other channel, or IDLE: HOLD if its opm != 0, else READY.
- Boundary cases:
  - Simultaneous requests from all channels: exactly one grant per transaction.
  - In mode 1, no channel waits more than NCH-1 transactions.
  - Granted channel drops opm mid-BUSY: the memory transaction still completes; DONE exits as soon as memOK returns to READY.
  - NCH = 1: arbitration degenerates to a pass-through with the handshake unchanged.
  - Reset mid-BUSY: memOpm goes READY immediately; the memory tile is responsible for discarding the partial operation.
- grantId is zero-extended when NCH < 8.

Decomposition:
- Shared definitions package (Jx2CoreDefs) holds:
  - UMEM_OPM_* and UMEM_OK_* constants.
  - New state encodings JX2_MARB_IDLE = 2'd0, JX2_MARB_BUSY = 2'd1, JX2_MARB_DONE = 2'd2.
- One sub-module: jx2_arb_pick. Purely combinational.
  - Inputs: request vector, rrPtr, mode.
  - Outputs: winner index and a valid bit.
  - Reused later by the interrupt controller.

Test Plan:
1. Mode 0, NCH=2: ch0 and ch1 request together; memOK returns OK 3 cycles after the grant with memDataI = 0x1122…FF → ch0 served first with chRspData 0x1122…FF; ch1 sees HOLD throughout, then is served immediately after ch0 drops opm.
2. Mode 1, NCH=4: all four channels request continuously for 8 transactions → grant order 0,1,2,3,0,1,2,3; no channel HOLDs longer than 3 transactions.
3. TMO_CYC=16: memOK held at HOLD → on the 16th BUSY cycle memOpm goes READY and the granted channel sees FAULT; next request is granted normally.
4. Granted channel changes chReqAddr from 0x1000 to 0x2000 mid-BUSY → memAddr stays 0x1000 until DONE.
5. reset pulsed low mid-BUSY → memOpm = READY and all chRspOK = READY in the same cycle (asynchronous); after release, state = IDLE and rrPtr = 0.
6. Granted channel keeps opm asserted 5 cycles into DONE → OK stays held for all 5 cycles; no new grant until it drops.
